uart_tx_scheduler: RTL
======================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one UART byte transmitter between NUM_REQ byte-stream requesters.
//  Round-robin arbitration, bounded bursts per grant, CTS flow control and a
//  programmable inter-byte idle gap. Sits between client logic and the
//  serializer, which uses a tx_start/tx_busy handshake.
// PARAMETERS
//  NUM_REQ      4        number of requesters (2..8)
//  REQ_W        2        width of grant_id, clog2(NUM_REQ)
//  BURST_LEN    4        max bytes sent per grant before rotating (>=1)
//  GAP_TICKS    104      clk cycles of idle after each byte (0 = no gap)
//  CTS_TIMEOUT  1200000  clk cycles of CTS deasserted before release + error
// PORTS
//  clk           in   1           system clock
//  reset         in   1           asynchronous, active-low reset
//  req_valid     in   NUM_REQ     requester i has a byte; hold until req_ready[i]
//  req_data      in   NUM_REQ*8   byte of requester i at [8*i+7:8*i]
//  req_ready     out  NUM_REQ     one-cycle accept pulse, one-hot
//  cts           in   1           peer clear-to-send, low = asserted
//  tx_start      out  1           one-cycle launch pulse to serializer
//  tx_data       out  8           byte to send, valid while tx_start=1
//  tx_busy       in   1           serializer busy; rises cycle after tx_start
//  grant_active  out  1           a requester currently holds the grant
//  grant_id      out  REQ_W       index of current/last granted requester
//  stall_err     out  1           sticky: CTS timeout occurred
//  err_clear     in   1           clears stall_err
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; req_ready=0, tx_start=0, tx_data=0,
//   grant_active=0, grant_id=0, stall_err=0; last_grant=NUM_REQ-1,
//   burst/gap/timeout counters 0. Reset mid-byte: outputs drop at once, no
//   accept issued, serializer finishes on its own.
//  FSM: IDLE -> WAIT_CTS -> LAUNCH -> WAIT_BUSY -> WAIT_DONE -> GAP -> ...
//  IDLE: if any req_valid, winner = first set bit scanning from last_grant+1
//   modulo NUM_REQ; register grant_id, grant_active=1, burst_cnt=0 -> WAIT_CTS.
//  WAIT_CTS: req_valid[grant_id]=0 -> release. cts=0 -> LAUNCH. cts=1:
//   timeout counter++; at CTS_TIMEOUT-1 set stall_err, release. Counter is
//   cleared on entry to WAIT_CTS.
//  LAUNCH (1 cycle): tx_start=1, tx_data=req_data[grant_id],
//   req_ready[grant_id]=1, burst_cnt++ -> WAIT_BUSY.
//  WAIT_BUSY: wait for tx_busy=1; if not seen within 4 cycles treat byte as
//   done -> GAP (protects against a dead serializer).
//  WAIT_DONE: wait tx_busy=0 -> GAP.
//  GAP: count GAP_TICKS cycles (skip if 0). Then if burst_cnt<BURST_LEN and
//   req_valid[grant_id] -> WAIT_CTS (same grant); else release.
//  Release: last_grant=grant_id, grant_active=0, grant_id holds value -> IDLE.
//  Max one byte in flight; accept only in LAUNCH; never two ready bits.
//  CTS rising during a byte does not abort it; it is checked before next byte.
//  stall_err: set wins over err_clear in the same cycle; otherwise cleared.
//  Counters sized to their parameter; no wrap in use (saturating compare).
// TESTING
//  1 Single req0, byte 0xA5, cts=0, GAP_TICKS=4 -> one tx_start with
//    tx_data=0xA5, req_ready[0] same cycle, grant released after gap.
//  2 All 4 valid, BURST_LEN=2, each with 3 bytes -> serve order 0,0,1,1,2,2,
//    3,3,0,1,2,3; never two req_ready bits high at once.
//  3 cts=1 held, CTS_TIMEOUT=50 -> no tx_start, stall_err=1 after 50 cycles,
//    grant rotates; err_clear pulse -> stall_err=0; set+clear same cycle -> 1.
//  4 cts high mid-burst for 20 cycles (<timeout) -> current byte completes,
//    next tx_start issued 1 cycle after cts returns low, same grant_id.
//  5 Serializer never raises tx_busy -> GAP entered 4 cycles after LAUNCH,
//    next byte still sent.
//  6 reset low during WAIT_DONE -> all outputs 0 immediately; after release
//    req1,req3 valid -> req1 granted first.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART byte serializer between NUM_REQ
// byte-stream requesters. Grants are held for at most BURST_LEN bytes, every
// byte waits for CTS (active low), and an idle gap follows each byte.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | no grant held; arbitrate among valid requesters
// WAIT_CTS   | grant held; wait for cts low, time out if it stays high
// LAUNCH     | one-cycle tx_start pulse, accept byte from granted requester
// WAIT_BUSY  | wait for serializer to raise tx_busy (bounded watchdog)
// WAIT_DONE  | wait for serializer to drop tx_busy
// GAP        | inter-byte idle; then continue burst or release grant
module uart_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int REQ_W       = 2,
  parameter int BURST_LEN   = 4,
  parameter int GAP_TICKS   = 104,
  parameter int CTS_TIMEOUT = 1200000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 cts,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_active,
  output logic [REQ_W-1:0]     grant_id,
  output logic                 stall_err,
  input  logic                 err_clear
);

  localparam int BURST_W = $clog2(BURST_LEN + 1);
  localparam int GAP_W   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int TO_W    = (CTS_TIMEOUT > 1) ? $clog2(CTS_TIMEOUT) : 1;

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST_LEN);
  localparam logic [GAP_W-1:0]   GAP_LOAD  = (GAP_TICKS > 0) ? GAP_W'(GAP_TICKS - 1) : '0;
  localparam logic [TO_W-1:0]    TO_LAST   = (CTS_TIMEOUT > 0) ? TO_W'(CTS_TIMEOUT - 1) : '0;
  // Watchdog load: tx_busy must appear within the launch cycle plus three more.
  localparam logic [1:0]         BUSY_LOAD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CTS,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t               state;
  state_t               state_nxt;
  state_t               after_gap;
  state_t               after_byte;

  logic [REQ_W-1:0]     last_grant;
  logic [REQ_W-1:0]     winner;
  logic                 any_req;
  logic                 grant_valid;
  logic [BURST_W-1:0]   burst_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic [1:0]           busy_cnt;
  logic                 stall_set;
  logic                 enter_wait_cts;
  logic                 enter_gap;
  logic                 release_grant;
  int                   scan_idx;

  assign any_req     = |req_valid;
  assign grant_valid = req_valid[grant_id];

  // Round-robin pick: first valid requester after last_grant, wrapping.
  always_comb begin
    winner   = '0;
    scan_idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = (int'(last_grant) + k) % NUM_REQ;
      if (req_valid[scan_idx]) winner = REQ_W'(scan_idx);
    end
  end

  // Burst continuation after the gap; zero gap skips the GAP state entirely.
  always_comb begin
    after_gap  = S_IDLE;
    after_byte = S_GAP;
    if ((burst_cnt < BURST_MAX) && grant_valid) after_gap = S_WAIT_CTS;
    if (GAP_TICKS == 0) after_byte = after_gap;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    stall_set = 1'b0;
    if (state == S_LAUNCH) req_ready[grant_id] = 1'b1;
    case (state)
      S_IDLE: begin
        if (any_req) state_nxt = S_WAIT_CTS;
      end
      S_WAIT_CTS: begin
        if (!grant_valid) begin
          state_nxt = S_IDLE;
        end else if (!cts) begin
          state_nxt = S_LAUNCH;
        end else if (to_cnt == TO_LAST) begin
          stall_set = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_LAUNCH: begin
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy)             state_nxt = S_WAIT_DONE;
        else if (busy_cnt == '0) state_nxt = after_byte;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_nxt = after_byte;
      end
      S_GAP: begin
        if (gap_cnt == '0) state_nxt = after_gap;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign tx_start       = (state == S_LAUNCH);
  assign tx_data        = tx_start ? req_data[int'(grant_id)*8 +: 8] : 8'h00;
  assign enter_wait_cts = (state_nxt == S_WAIT_CTS) && (state != S_WAIT_CTS);
  assign enter_gap      = (state_nxt == S_GAP) && (state != S_GAP);
  assign release_grant  = (state_nxt == S_IDLE) && (state != S_IDLE);

  // Grant bookkeeping: capture winner, remember it on release for rotation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_active <= 1'b0;
      grant_id     <= '0;
      last_grant   <= REQ_W'(NUM_REQ - 1);
    end else if (state == S_IDLE && any_req) begin
      grant_active <= 1'b1;
      grant_id     <= winner;
    end else if (release_grant) begin
      grant_active <= 1'b0;
      last_grant   <= grant_id;
    end
  end

  // Bytes sent under the current grant; saturates at BURST_LEN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt <= '0;
    end else if (state == S_IDLE && any_req) begin
      burst_cnt <= '0;
    end else if (state == S_LAUNCH && burst_cnt != BURST_MAX) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // CTS wait timer, restarted on every entry to WAIT_CTS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (enter_wait_cts) begin
      to_cnt <= '0;
    end else if (state == S_WAIT_CTS && grant_valid && cts && to_cnt != TO_LAST) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Dead-serializer watchdog, loaded during the launch cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cnt <= '0;
    end else if (state == S_LAUNCH) begin
      busy_cnt <= BUSY_LOAD;
    end else if (state == S_WAIT_BUSY && busy_cnt != '0) begin
      busy_cnt <= busy_cnt - 1'b1;
    end
  end

  // Inter-byte gap down-counter; terminal count at zero ends the gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt <= '0;
    end else if (enter_gap) begin
      gap_cnt <= GAP_LOAD;
    end else if (state == S_GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Sticky CTS timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         stall_err <= 1'b0;
    else if (stall_set) stall_err <= 1'b1;
    else if (err_clear) stall_err <= 1'b0;
  end

endmodule
